// File: rtl/iq_age_select_pkg.sv
// Shared issue-queue sizing constants used by the age-select control block.
package iq_age_select_pkg;

  localparam int unsigned IQ_DEPTH_DEF = 8;
  localparam int unsigned IQ_IDX_W_DEF = $clog2(IQ_DEPTH_DEF);

endpackage

// File: rtl/iq_age_select_age_matrix.sv
// Age matrix for one issue queue: records relative allocation order and picks the
// oldest ready candidate.
module iq_age_matrix
  import iq_age_select_pkg::*;
#(
  parameter int unsigned IQ_DEPTH = IQ_DEPTH_DEF
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                flush,
  input  logic [IQ_DEPTH-1:0] enq_oh,
  input  logic [IQ_DEPTH-1:0] cand,
  output logic [IQ_DEPTH-1:0] winner_oh
);

  // age_q[i][j] set means entry i is older than entry j
  logic [IQ_DEPTH-1:0][IQ_DEPTH-1:0] age_q;
  logic [IQ_DEPTH-1:0][IQ_DEPTH-1:0] age_d;

  // Newly allocated entry becomes younger than every other entry
  always_comb begin
    age_d = age_q;
    for (int k = 0; k < int'(IQ_DEPTH); k++) begin
      if (enq_oh[k]) begin
        for (int j = 0; j < int'(IQ_DEPTH); j++) begin
          if (j != k) begin
            age_d[j][k] = 1'b1;
            age_d[k][j] = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n || flush) begin
      age_q <= '0;
    end else begin
      age_q <= age_d;
    end
  end

  // An entry wins only if it is older than every other candidate
  always_comb begin
    winner_oh = '0;
    for (int i = 0; i < int'(IQ_DEPTH); i++) begin
      winner_oh[i] = cand[i];
      for (int j = 0; j < int'(IQ_DEPTH); j++) begin
        if (j != i && cand[j] && !age_q[i][j]) begin
          winner_oh[i] = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/iq_age_select.sv
// Issue-queue control: free-entry allocation, oldest-ready select and a one-deep
// issue register toward the functional unit.
module iq_age_select
  import iq_age_select_pkg::*;
#(
  parameter int unsigned IQ_DEPTH = IQ_DEPTH_DEF,
  parameter int unsigned IQ_IDX_W = $clog2(IQ_DEPTH)
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                flush,
  input  logic [IQ_DEPTH-1:0] entry_valid,
  input  logic [IQ_DEPTH-1:0] entry_ready,
  input  logic                enq_valid,
  output logic                enq_ready,
  output logic [IQ_DEPTH-1:0] enq_entry_oh,
  output logic [IQ_DEPTH-1:0] issuing,
  output logic                iss_load,
  output logic                iss_valid,
  output logic [IQ_IDX_W-1:0] iss_entry_idx,
  input  logic                deq_ready,
  output logic [IQ_IDX_W:0]   occupancy
);

  localparam int unsigned OCC_W = IQ_IDX_W + 1;

  logic [IQ_DEPTH-1:0] free;
  logic [IQ_DEPTH-1:0] low_free_oh;
  logic                low_found;
  logic [IQ_DEPTH-1:0] cand;
  logic [IQ_DEPTH-1:0] winner_oh;
  logic                can_load;
  logic [IQ_IDX_W-1:0] iss_idx_d;
  logic [OCC_W-1:0]    occ_d;

  // Allocation: lowest free slot, blocked during flush
  always_comb begin
    free        = ~entry_valid;
    low_free_oh = '0;
    low_found   = 1'b0;
    for (int i = 0; i < int'(IQ_DEPTH); i++) begin
      if (free[i] && !low_found) begin
        low_free_oh[i] = 1'b1;
        low_found      = 1'b1;
      end
    end
    enq_ready    = (|free) & ~flush;
    enq_entry_oh = (enq_valid & enq_ready) ? low_free_oh : '0;
  end

  assign cand = entry_ready & entry_valid;

  iq_age_matrix #(
    .IQ_DEPTH (IQ_DEPTH)
  ) u_age_matrix (
    .clock     (clock),
    .reset_n   (reset_n),
    .flush     (flush),
    .enq_oh    (enq_entry_oh),
    .cand      (cand),
    .winner_oh (winner_oh)
  );

  // Issue only when the register is empty or draining this cycle
  always_comb begin
    can_load = ~iss_valid | deq_ready;
    issuing  = winner_oh & {IQ_DEPTH{can_load & ~flush}};
    iss_load = |issuing;
    iss_idx_d = '0;
    for (int i = 0; i < int'(IQ_DEPTH); i++) begin
      if (issuing[i]) begin
        iss_idx_d = IQ_IDX_W'(i);
      end
    end
  end

  always_comb begin
    occ_d = '0;
    for (int i = 0; i < int'(IQ_DEPTH); i++) begin
      occ_d = occ_d + OCC_W'(entry_valid[i]);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      iss_valid     <= 1'b0;
      iss_entry_idx <= '0;
      occupancy     <= '0;
    end else if (flush) begin
      iss_valid     <= 1'b0;
      occupancy     <= '0;
    end else begin
      occupancy <= occ_d;
      if (iss_load) begin
        iss_valid     <= 1'b1;
        iss_entry_idx <= iss_idx_d;
      end else if (deq_ready) begin
        iss_valid     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_iq_age_select.sv
// Directed bench for iq_age_select with a timestamp-based reference model.
module tb_iq_age_select;

  localparam int D = 8;

  logic       clock = 1'b0;
  logic       reset_n, flush, enq_valid, deq_ready;
  logic [7:0] entry_valid, entry_ready;
  logic       enq_ready, iss_load, iss_valid;
  logic [7:0] enq_entry_oh, issuing;
  logic [2:0] iss_entry_idx;
  logic [3:0] occupancy;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  // Model state: allocation stamp per entry (0 = not allocated since last clear)
  int         t [D];
  int         now = 1;
  logic       m_iss_valid;
  logic [2:0] m_iss_idx;
  logic [3:0] m_occ;

  logic       x_enq_ready;
  logic [7:0] x_enq_oh, x_win, x_iss;

  always #5 clock = ~clock;

  iq_age_select dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .flush         (flush),
    .entry_valid   (entry_valid),
    .entry_ready   (entry_ready),
    .enq_valid     (enq_valid),
    .enq_ready     (enq_ready),
    .enq_entry_oh  (enq_entry_oh),
    .issuing       (issuing),
    .iss_load      (iss_load),
    .iss_valid     (iss_valid),
    .iss_entry_idx (iss_entry_idx),
    .deq_ready     (deq_ready),
    .occupancy     (occupancy)
  );

  // Expected combinational outputs: oldest = smallest allocation stamp
  always_comb begin
    x_enq_ready = (entry_valid != 8'hFF) && !flush;
    x_enq_oh    = '0;
    if (enq_valid && x_enq_ready) begin
      for (int i = D - 1; i >= 0; i--) begin
        if (!entry_valid[i]) x_enq_oh = 8'(1) << i;
      end
    end
    x_win = '0;
    for (int i = 0; i < D; i++) begin
      if (entry_valid[i] && entry_ready[i]) begin
        x_win[i] = 1'b1;
        for (int j = 0; j < D; j++) begin
          if (j != i && entry_valid[j] && entry_ready[j] && !(t[j] > 0 && t[i] < t[j]))
            x_win[i] = 1'b0;
        end
      end
    end
    x_iss = ((!m_iss_valid || deq_ready) && !flush) ? x_win : 8'h00;
  end

  always @(posedge clock) begin
    now <= now + 1;
    if (!reset_n || flush) begin
      m_iss_valid <= 1'b0;
      m_occ       <= 4'd0;
      if (!reset_n) m_iss_idx <= 3'd0;
      for (int i = 0; i < D; i++) t[i] <= 0;
    end else begin
      m_occ <= 4'($countones(entry_valid));
      if (x_iss != 8'h00) begin
        m_iss_valid <= 1'b1;
        for (int i = 0; i < D; i++) if (x_iss[i]) m_iss_idx <= 3'(i);
      end else if (deq_ready) begin
        m_iss_valid <= 1'b0;
      end
      for (int i = 0; i < D; i++) if (x_enq_oh[i]) t[i] <= now;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      check("m_enq_ready", 32'(enq_ready), 32'(x_enq_ready));
      check("m_enq_oh", 32'(enq_entry_oh), 32'(x_enq_oh));
      check("m_issuing", 32'(issuing), 32'(x_iss));
      check("m_iss_load", 32'(iss_load), 32'(x_iss != 8'h00));
      check("m_iss_valid", 32'(iss_valid), 32'(m_iss_valid));
      check("m_iss_idx", 32'(iss_entry_idx), 32'(m_iss_idx));
      check("m_occupancy", 32'(occupancy), 32'(m_occ));
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [7:0] ev, input logic [7:0] er, input logic eq,
                       input logic dr, input logic fl);
    entry_valid = ev;
    entry_ready = er;
    enq_valid   = eq;
    deq_ready   = dr;
    flush       = fl;
  endtask

  initial begin
    reset_n = 1'b0;
    drive(8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    cyc();
    chk_en = 1'b1;
    cyc();
    reset_n = 1'b1;

    // Empty queue after reset
    drive(8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
    #1;
    check("rst_enq_ready", 32'(enq_ready), 32'd1);
    check("rst_enq_oh", 32'(enq_entry_oh), 32'h01);
    check("rst_issuing", 32'(issuing), 32'h00);
    check("rst_iss_valid", 32'(iss_valid), 32'd0);
    check("rst_occupancy", 32'(occupancy), 32'd0);
    enq_valid = 1'b0;
    cyc();

    // Allocate entries 2, 5, 0 in that order
    drive(8'h03, 8'h00, 1'b1, 1'b1, 1'b0);
    #1; check("enq_e2", 32'(enq_entry_oh), 32'h04);
    cyc();
    drive(8'h1F, 8'h00, 1'b1, 1'b1, 1'b0);
    #1; check("enq_e5", 32'(enq_entry_oh), 32'h20);
    cyc();
    drive(8'h24, 8'h00, 1'b1, 1'b1, 1'b0);
    #1; check("enq_e0", 32'(enq_entry_oh), 32'h01);
    cyc();

    // Oldest-ready select, back-to-back with deq_ready high
    drive(8'h25, 8'h25, 1'b0, 1'b1, 1'b0);
    #1; check("sel_oldest_e2", 32'(issuing), 32'h04);
    cyc();
    drive(8'h21, 8'h21, 1'b0, 1'b1, 1'b0);
    #1;
    check("sel_next_e5", 32'(issuing), 32'h20);
    check("b2b_iss_idx2", 32'(iss_entry_idx), 32'd2);
    cyc();
    drive(8'h01, 8'h01, 1'b0, 1'b1, 1'b0);
    #1;
    check("sel_last_e0", 32'(issuing), 32'h01);
    check("b2b_iss_idx5", 32'(iss_entry_idx), 32'd5);
    check("b2b_iss_valid", 32'(iss_valid), 32'd1);
    cyc();
    drive(8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
    cyc();

    // Full queue blocks allocation; one hole reopens it
    drive(8'hFF, 8'h00, 1'b1, 1'b1, 1'b0);
    #1;
    check("full_enq_ready", 32'(enq_ready), 32'd0);
    check("full_enq_oh", 32'(enq_entry_oh), 32'h00);
    cyc();
    drive(8'hF7, 8'h00, 1'b1, 1'b1, 1'b0);
    #1;
    check("hole_enq_oh", 32'(enq_entry_oh), 32'h08);
    check("full_occupancy", 32'(occupancy), 32'd8);
    cyc();

    // Stall: register held while deq_ready low
    drive(8'h0A, 8'h08, 1'b0, 1'b1, 1'b0);
    #1; check("load_e3", 32'(issuing), 32'h08);
    cyc();
    for (int c = 0; c < 3; c++) begin
      drive(8'h02, 8'h02, 1'b0, 1'b0, 1'b0);
      #1;
      check("stall_issuing", 32'(issuing), 32'h00);
      check("stall_iss_valid", 32'(iss_valid), 32'd1);
      check("stall_iss_idx", 32'(iss_entry_idx), 32'd3);
      cyc();
    end
    drive(8'h02, 8'h02, 1'b0, 1'b1, 1'b0);
    #1; check("unstall_issuing", 32'(issuing), 32'h02);
    cyc();

    // Flush with a held instruction and two ready entries
    drive(8'h28, 8'h28, 1'b1, 1'b0, 1'b1);
    #1;
    check("unstall_iss_idx", 32'(iss_entry_idx), 32'd1);
    check("unstall_iss_valid", 32'(iss_valid), 32'd1);
    check("flush_issuing", 32'(issuing), 32'h00);
    check("flush_enq_ready", 32'(enq_ready), 32'd0);
    check("flush_enq_oh", 32'(enq_entry_oh), 32'h00);
    cyc();
    // Ages cleared: two unallocated candidates cannot win
    drive(8'h28, 8'h28, 1'b0, 1'b1, 1'b0);
    #1;
    check("post_flush_iss_valid", 32'(iss_valid), 32'd0);
    check("post_flush_occupancy", 32'(occupancy), 32'd0);
    check("post_flush_no_winner", 32'(issuing), 32'h00);
    cyc();

    // Reset is only sampled at the clock edge
    drive(8'h08, 8'h08, 1'b0, 1'b1, 1'b0);
    cyc();
    drive(8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b0;
    #2;
    check("rst_between_edges", 32'(iss_valid), 32'd1);
    #1;
    reset_n = 1'b1;
    cyc();
    check("rst_glitch_iss_valid", 32'(iss_valid), 32'd1);
    check("rst_glitch_iss_idx", 32'(iss_entry_idx), 32'd3);
    reset_n = 1'b0;
    cyc();
    check("rst_mid_iss_valid", 32'(iss_valid), 32'd0);
    check("rst_mid_iss_idx", 32'(iss_entry_idx), 32'd0);
    check("rst_mid_occupancy", 32'(occupancy), 32'd0);
    reset_n = 1'b1;
    cyc();
    cyc();
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
